mul_div_iter: RTL and testbench
===============================

Name: mul_div_iter

Overview:
Parametrised iterative multiply/divide unit, the successor to the single-bit shift-add multiplier embedded in the execute stage. It adds signed/unsigned and high/low multiply variants, divide/remainder, and a configurable radix (bits retired per cycle). It sits beside the execute stage: execute pulses start and stalls on busy, then writes result into the destination register and result_hi into the HI register (register 7).

Parameters:
RV, 32, operand/result width; 16 or 32.
BPC, 1, bits retired per iteration; 1, 2 or 4; must divide RV.
DIV, 1, 1 = divide ops implemented; 0 = ops 4-7 complete as MULHU-free no-ops returning 0.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  launch operation; sampled only in IDLE or DONE
op  in  3  0 MUL, 1 MULH (s×s), 2 MULHSU (s×u), 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  in  RV  operand 1 (multiplicand / dividend)
b  in  RV  operand 2 (multiplier / divisor)
kill  in  1  abort the in-flight operation (trap/interrupt/flush)
busy  out  1  high in RUN and FIX
done  out  1  one-cycle pulse; result and result_hi valid
result  out  RV  MUL: low product; MULH*: high product; DIV*: quotient; REM*: remainder
result_hi  out  RV  the other half: product high for op 0, product low for ops 1-3, remainder for 4/5, quotient for 6/7

Behaviour:
- States: IDLE, RUN, FIX, DONE. Reset (any state) -> IDLE, busy=0, done=0, result=0, result_hi=0, counter=0.
- IDLE/DONE + start: latch op, sign flags, |a|, |b| (signed ops only take magnitude; MULHSU takes magnitude of a only). Enter RUN with counter=RV/BPC-1. start without kill is accepted in DONE (back-to-back, no bubble).
- RUN: each cycle retires BPC bits. Multiply: accumulator (2*RV) += partial product of BPC multiplier bits, shifted. Divide: BPC restoring-divide steps on {rem, quot}. At counter==0 -> FIX, else counter-1.
- FIX (1 cycle): negate product if signs differ (signed ops); quotient negated if sign(a)^sign(b), remainder takes sign of a; load result/result_hi; -> DONE.
- DONE (1 cycle): done=1, busy=0; -> IDLE unless start.
- Latency: start high in cycle 0 -> RUN cycles 1..RV/BPC -> FIX cycle RV/BPC+1 -> done in cycle RV/BPC+2 (34 for RV=32, BPC=1; 10 for BPC=4).
- Divide by zero (DIV=1, ops 4-7, b==0): skip RUN; FIX in cycle 1, done in cycle 2; quotient=all ones, remainder=a (unchanged, no sign fix).
- Signed overflow (DIV/REM, a=-2^(RV-1), b=-1): quotient=a, remainder=0, normal latency.
- kill: in RUN/FIX -> IDLE next cycle, no done pulse, result/result_hi keep previous values. kill with start in same cycle: start ignored. kill in IDLE/DONE: no effect other than suppressing start.
- start while busy: ignored; execute must hold until done.
- result/result_hi hold their value until the next FIX; outputs are registered.
- Operands a/b need only be valid in the start cycle.

Test Plan:
- MUL a=7,b=6, BPC=1 -> done in cycle 34, result=42, result_hi=0; busy high cycles 1-33.
- MULH a=0xFFFFFFFF,b=0xFFFFFFFF -> result=0, result_hi=1; MULHU same operands -> result=0xFFFFFFFE, result_hi=1.
- DIV a=-7,b=2 -> result=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1); REMU a=100,b=7 -> result=2, result_hi=14.
- DIVU a=5,b=0 -> done in cycle 2, result=0xFFFFFFFF, result_hi=5; DIV a=0x80000000,b=-1 -> result=0x80000000, result_hi=0.
- Start MUL, assert kill in cycle 10 -> no done, busy low cycle 11, result unchanged; new start cycle 11 completes normally.
- BPC=4, RV=16: MUL 0x1234*0x0010 -> done in cycle 6, result=0x2340, result_hi=0x0001; back-to-back start in DONE cycle -> second done exactly 6 cycles later.

Source files
------------

// File: rtl/mul_div_iter.sv
// Iterative multiply/divide unit retiring BPC bits per cycle.
// Signed operands are reduced to magnitudes at start; signs are restored in FIX.
module mul_div_iter #(
  parameter int RV  = 32,
  parameter int BPC = 1,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RV-1:0] a,
  input  logic [RV-1:0] b,
  input  logic          kill,
  output logic          busy,
  output logic          done,
  output logic [RV-1:0] result,
  output logic [RV-1:0] result_hi
);
  localparam int NIT = RV / BPC;
  localparam int CW  = (NIT > 1) ? $clog2(NIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*RV-1:0] acc_q, acc_d;
  logic [RV-1:0]   opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d, skip_q, skip_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [RV-1:0]   res_q, res_d, res_hi_q, res_hi_d;

  logic            sgn_a_s, sgn_b_s, skip_run_s;
  logic [RV-1:0]   abs_a_s, abs_b_s;
  logic [RV+BPC-1:0] mul_sum_s;
  logic [2*RV-1:0] mul_next_s, div_next_s, prod_s;
  logic [RV:0]     r_s;
  logic [RV-1:0]   qt_s, quot_s, rem_s;

  // Start-cycle operand conditioning: sign flags and magnitudes
  always_comb begin
    sgn_a_s    = a[RV-1] && (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd6);
    sgn_b_s    = b[RV-1] && (op == 3'd1 || op == 3'd4 || op == 3'd6);
    abs_a_s    = sgn_a_s ? -a : a;
    abs_b_s    = sgn_b_s ? -b : b;
    skip_run_s = op[2] && ((DIV == 0) || (b == '0));
  end

  // One multiply iteration: add BPC-bit partial product to the high half, shift right
  always_comb begin
    mul_sum_s  = {{BPC{1'b0}}, acc_q[2*RV-1:RV]}
               + ({{BPC{1'b0}}, opnd_q} * {{RV{1'b0}}, acc_q[BPC-1:0]});
    mul_next_s = {mul_sum_s, acc_q[RV-1:BPC]};
  end

  // BPC restoring-divide steps on {remainder, quotient}
  always_comb begin
    r_s  = {1'b0, acc_q[2*RV-1:RV]};
    qt_s = acc_q[RV-1:0];
    for (int k = 0; k < BPC; k++) begin
      r_s  = {r_s[RV-1:0], qt_s[RV-1]};
      qt_s = {qt_s[RV-2:0], 1'b0};
      if (r_s >= {1'b0, opnd_q}) begin
        r_s     = r_s - {1'b0, opnd_q};
        qt_s[0] = 1'b1;
      end else begin
        qt_s[0] = 1'b0;
      end
    end
    div_next_s = {r_s[RV-1:0], qt_s};
  end

  // Sign restoration; a divide-by-zero quotient stays all ones, its remainder returns to a
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot_s = ((sa_q ^ sb_q) && !skip_q) ? -acc_q[RV-1:0] : acc_q[RV-1:0];
    rem_s  = sa_q ? -acc_q[2*RV-1:RV] : acc_q[2*RV-1:RV];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    skip_d   = skip_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !kill) begin
          op_d   = op;
          sa_d   = sgn_a_s;
          sb_d   = sgn_b_s;
          skip_d = skip_run_s;
          if (op[2]) begin
            opnd_d = abs_b_s;
            acc_d  = {{RV{1'b0}}, abs_a_s};
          end else begin
            opnd_d = abs_a_s;
            acc_d  = {{RV{1'b0}}, abs_b_s};
          end
          if (skip_run_s) begin
            acc_d   = {abs_a_s, {RV{1'b1}}};
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d   = CW'(NIT - 1);
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = op_q[2] ? div_next_s : mul_next_s;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          case (op_q)
            3'd0: begin
              res_d    = prod_s[RV-1:0];
              res_hi_d = prod_s[2*RV-1:RV];
            end
            3'd1, 3'd2, 3'd3: begin
              res_d    = prod_s[2*RV-1:RV];
              res_hi_d = prod_s[RV-1:0];
            end
            3'd4, 3'd5: begin
              res_d    = (DIV != 0) ? quot_s : '0;
              res_hi_d = (DIV != 0) ? rem_s : '0;
            end
            default: begin
              res_d    = (DIV != 0) ? rem_s : '0;
              res_hi_d = (DIV != 0) ? quot_s : '0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      skip_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      skip_q   <= skip_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign result_hi = res_hi_q;
endmodule

// File: tb/tb_mul_div_iter.sv
// Scoreboard bench for mul_div_iter: a 32-bit radix-2 instance and a 16-bit radix-16 instance.
module tb_mul_div_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, kill, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, result, result_hi;
  logic        start16, kill16, busy16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16, result_hi16;

  mul_div_iter #(.RV(32), .BPC(1), .DIV(1)) dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi));

  mul_div_iter #(.RV(16), .BPC(4), .DIV(1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16), .kill(kill16),
    .busy(busy16), .done(done16), .result(result16), .result_hi(result_hi16));

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [31:0] hi;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        q32[$];
  exp_t        q16[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] last_res, last_hi;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {result, result_hi}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] xi, input logic [31:0] yi,
                                        input int w);
    logic [31:0]  msk, x, y, lo, hi, q, r;
    logic [127:0] ea, eb, p;
    logic         sga, sgb;
    msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    x   = xi & msk;
    y   = yi & msk;
    sga = (o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd6) && x[w-1];
    sgb = (o == 3'd1 || o == 3'd4 || o == 3'd6) && y[w-1];
    ea  = {96'd0, x};
    eb  = {96'd0, y};
    if (sga) ea = ea | ({128{1'b1}} << w);
    if (sgb) eb = eb | ({128{1'b1}} << w);
    p  = ea * eb;
    lo = p[31:0] & msk;
    hi = 32'(p >> w) & msk;
    if (y == 32'd0) begin
      q = msk;
      r = x;
    end else if (o == 3'd4 || o == 3'd6) begin
      q = 32'($signed(ea[63:0]) / $signed(eb[63:0])) & msk;
      r = 32'($signed(ea[63:0]) % $signed(eb[63:0])) & msk;
    end else begin
      q = 32'(ea[63:0] / eb[63:0]) & msk;
      r = 32'(ea[63:0] % eb[63:0]) & msk;
    end
    case (o)
      3'd0:             return {lo, hi};
      3'd1, 3'd2, 3'd3: return {hi, lo};
      3'd4, 3'd5:       return {q, r};
      default:          return {r, q};
    endcase
  endfunction

  task automatic issue(input bit w16, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input bit expect_done, input string tag);
    logic [63:0] m;
    exp_t        e;
    m     = model(o, x, y, w16 ? 16 : 32);
    e.tag = tag;
    e.res = m[63:32];
    e.hi  = m[31:0];
    e.t0  = cyc;
    e.lat = lat;
    if (expect_done) begin
      if (w16) begin
        q16.push_back(e);
      end else begin
        q32.push_back(e);
        last_res = e.res;
        last_hi  = e.hi;
      end
    end
    if (w16) begin
      start16 = 1'b1; op16 = o; a16 = x[15:0]; b16 = y[15:0];
    end else begin
      start = 1'b1; op = o; a = x; b = y;
    end
    @(negedge clk);
    start   = 1'b0;
    start16 = 1'b0;
    a       = $urandom;
    b       = $urandom;
    a16     = 16'($urandom);
    b16     = 16'($urandom);
  endtask

  task automatic wait_done(input bit w16, output int nb);
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      if (w16 ? done16 : done) return;
      if (w16 ? busy16 : busy) nb++;
      @(negedge clk);
    end
    check_eq("done timeout", 64'(w16 ? done16 : done), 64'd1);
  endtask

  // Scoreboard for the 32-bit instance
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && done) begin
      if (q32.size() == 0) begin
        check_eq("dut32 unexpected done", 64'(done), 64'd0);
      end else begin
        e = q32.pop_front();
        check_eq({e.tag, " result"}, 64'(result), 64'(e.res));
        check_eq({e.tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
        check_eq({e.tag, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Scoreboard for the 16-bit instance
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!reset && done16) begin
      if (q16.size() == 0) begin
        check_eq("dut16 unexpected done", 64'(done16), 64'd0);
      end else begin
        e = q16.pop_front();
        check_eq({e.tag, " result"}, 64'(result16), 64'(e.res));
        check_eq({e.tag, " result_hi"}, 64'(result_hi16), 64'(e.hi));
        check_eq({e.tag, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb;
    logic [2:0]  o;
    logic [31:0] x, y;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    start16 = 1'b0; kill16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
    last_res = 32'd0; last_hi = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset result", 64'(result), 64'd0);
    check_eq("reset result_hi", 64'(result_hi), 64'd0);
    check_eq("reset busy16", 64'(busy16), 64'd0);
    check_eq("reset result16", 64'(result16), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 3'd0, 32'd7, 32'd6, 34, 1'b1, "mul 7x6");
    wait_done(1'b0, nb);
    check_eq("mul busy cycles", 64'(nb), 64'd33);
    @(negedge clk);
    issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1, "mulh -1x-1");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1, "mulhu max");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd3, 34, 1'b1, "mulhsu -1x3");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 34, 1'b1, "div -7/2");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 34, 1'b1, "rem -7/2");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd7, 32'd100, 32'd7, 34, 1'b1, "remu 100/7");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd5, 32'd5, 32'd0, 2, 1'b1, "divu 5/0");
    wait_done(1'b0, nb);
    check_eq("div0 busy cycles", 64'(nb), 64'd1);
    issue(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd0, 2, 1'b1, "rem -7/0");
    wait_done(1'b0, nb);
    issue(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1'b1, "div overflow");
    wait_done(1'b0, nb);

    issue(1'b0, 3'd5, 32'd1000, 32'd9, 34, 1'b1, "divu with late start");
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);

    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i == 3) ? 32'd0 : $urandom;
      issue(1'b0, o, x, y, (o[2] && y == 32'd0) ? 2 : 34, 1'b1, "rand32");
      wait_done(1'b0, nb);
    end

    issue(1'b0, 3'd0, 32'h1234, 32'h5678, 0, 1'b0, "killed mul");
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill busy", 64'(busy), 64'd0);
    check_eq("kill done", 64'(done), 64'd0);
    check_eq("kill result kept", 64'(result), 64'(last_res));
    check_eq("kill result_hi kept", 64'(result_hi), 64'(last_hi));
    issue(1'b0, 3'd0, 32'd123, 32'd456, 34, 1'b1, "mul after kill");
    wait_done(1'b0, nb);

    kill = 1'b1;
    issue(1'b0, 3'd0, 32'd3, 32'd3, 0, 1'b0, "start with kill");
    kill = 1'b0;
    check_eq("start+kill busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    issue(1'b1, 3'd0, 32'h1234, 32'h0010, 6, 1'b1, "mul16 0x1234x0x10");
    wait_done(1'b1, nb);
    check_eq("mul16 busy cycles", 64'(nb), 64'd5);
    issue(1'b1, 3'd3, 32'hFFFF, 32'hFFFF, 6, 1'b1, "mulhu16 back-to-back");
    wait_done(1'b1, nb);
    issue(1'b1, 3'd4, 32'hFFF9, 32'h0002, 6, 1'b1, "div16 -7/2");
    wait_done(1'b1, nb);
    issue(1'b1, 3'd4, 32'h8000, 32'hFFFF, 6, 1'b1, "div16 overflow");
    wait_done(1'b1, nb);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      issue(1'b1, o, x, y, (o[2] && y[15:0] == 16'd0) ? 2 : 6, 1'b1, "rand16");
      wait_done(1'b1, nb);
    end

    repeat (5) @(negedge clk);
    check_eq("q32 drained", 64'(q32.size()), 64'd0);
    check_eq("q16 drained", 64'(q16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
